// File: rtl/sum_arb_pkg.sv
// Shared definitions for the round-robin adder arbiter.
//   BUS_WIDTH_DEF : default operand/result width
//   arb_state_t   : arbiter FSM states
//   next_rr       : round-robin pointer advance with wrap
package sum_arb_pkg;

    localparam int BUS_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    // Pointer to the slot after ptr, wrapping back to 0 past num_req-1.
    function automatic int unsigned next_rr(input int unsigned ptr,
                                            input int unsigned num_req);
        return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sum.sv
// Existing shared adder datapath.
//   a, b          : operands (BUS_WIDTH)
//   sum_out       : a + b modulo 2^BUS_WIDTH
//   carry_bit_out : bit BUS_WIDTH of the full sum
module sum #(
    parameter int BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    output logic [BUS_WIDTH-1:0] sum_out,
    output logic                 carry_bit_out
);

    assign {carry_bit_out, sum_out} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sum_rr_grant.sv
// Combinational round-robin picker.
//   req_valid : per-requester request lines
//   rr_ptr    : highest-priority requester this round
//   grant_vld : some requester is valid
//   grant_idx : first valid requester at or after rr_ptr, wrapping
module sum_rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_vld,
    output logic [ID_W-1:0]    grant_idx
);

    int unsigned idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(rr_ptr) + off) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one `sum` adder among NUM_REQ requesters.
// Each transaction runs IDLE (grant + operand capture) -> EXEC (adder
// result registered) -> RESP (held until rsp_ready).
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_op1/req_op2     : flattened operands, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_sum/rsp_carry : registered owner, sum and carry
//   busy                : FSM not in IDLE
//   carry_cnt           : (only with SUM_ARB_CARRY_CNT_EN) saturating count of
//                         response handshakes carrying rsp_carry=1
module sum_arbiter
    import sum_arb_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_op2,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [BUS_WIDTH-1:0]         rsp_sum,
    output logic                         rsp_carry,
`ifdef SUM_ARB_CARRY_CNT_EN
    output logic [15:0]                  carry_cnt,
`endif
    output logic                         busy
);

    arb_state_t           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      id_q;
    logic [BUS_WIDTH-1:0] op1_q;
    logic [BUS_WIDTH-1:0] op2_q;
    logic [BUS_WIDTH-1:0] sum_out;
    logic                 carry_out;
    logic                 grant_vld;
    logic [ID_W-1:0]      grant_idx;

    sum_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    sum #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_sum (
        .a             (op1_q),
        .b             (op2_q),
        .sum_out       (sum_out),
        .carry_bit_out (carry_out)
    );

    // The picked requester is always valid, so ready on it is the handshake.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op1_q  <= req_op1[grant_idx*BUS_WIDTH +: BUS_WIDTH];
                        op2_q  <= req_op2[grant_idx*BUS_WIDTH +: BUS_WIDTH];
                        id_q   <= grant_idx;
                        rr_ptr <= ID_W'(next_rr(32'(grant_idx), 32'(NUM_REQ)));
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_out;
                    rsp_carry <= carry_out;
                    rsp_id    <= id_q;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUM_ARB_CARRY_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (state == RESP && rsp_ready && rsp_carry && carry_cnt != '1) begin
            carry_cnt <= carry_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// Self-checking bench for sum_arbiter (NUM_REQ=4, BUS_WIDTH=32).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sum_arbiter;

    localparam int NR = 4;
    localparam int BW = 32;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*BW-1:0]  req_op1;
    logic [NR*BW-1:0]  req_op2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [BW-1:0]     rsp_sum;
    logic              rsp_carry;
    logic              busy;
`ifdef SUM_ARB_CARRY_CNT_EN
    logic [15:0]       carry_cnt;
`endif

    sum_arbiter #(
        .BUS_WIDTH (BW),
        .NUM_REQ   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
`ifdef SUM_ARB_CARRY_CNT_EN
        .carry_cnt (carry_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [BW-1:0] s;
        logic          c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: push the expected response for requester i.
    task automatic push_exp(input int i);
        exp_t        e;
        logic [BW:0] full;
        full = {1'b0, req_op1[i*BW +: BW]} + {1'b0, req_op2[i*BW +: BW]};
        e.id = 2'(i);
        e.s  = full[BW-1:0];
        e.c  = full[BW];
        sb.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
        req_op1[i*BW +: BW] = a;
        req_op2[i*BW +: BW] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Bounded wait for rsp_valid; caller judges ok.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_op1 = '0; req_op2 = '0;
        @(negedge clk); #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%0d sum=%h c=%b busy=%b, required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy);
        end
`ifdef SUM_ARB_CARRY_CNT_EN
        total++;
        if (carry_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_carry_cnt: got %0d required 0", carry_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0; #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        set_ops(0, 32'h0000_0005, 32'h0000_0003);
        @(negedge clk); req_valid = 4'b0001; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_ready: got %b required 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk); req_valid = '0; #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_exec: rsp_valid=%b busy=%b required 0 1", rsp_valid, busy);
        end
        @(negedge clk); #1;
        total++;
        e = sb.pop_front();
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, e.id, e.s, e.c} || e.s !== 32'h8) begin
            bad++;
            $display("FAIL single_rsp: got v=%b id=%0d sum=%h c=%b required v=1 id=%0d sum=%h c=%b",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry, e.id, e.s, e.c);
        end
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_done: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_carry();
        exp_t e;
        bit   ok;
        do_reset();
        set_ops(2, 32'hFFFF_FFFF, 32'h0000_0001);
        rsp_ready = 1'b1;
        @(negedge clk); req_valid = 4'b0100; #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL carry_ready: got %b required 0100", req_ready);
        end
        push_exp(2);
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL carry_timeout: rsp_valid=%b required 1", rsp_valid);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c} || {e.id, e.s, e.c} !== {2'd2, 32'h0, 1'b1}) begin
                bad++;
                $display("FAIL carry_rsp: got id=%0d sum=%h c=%b required id=2 sum=00000000 c=1",
                         rsp_id, rsp_sum, rsp_carry);
            end
        end
        @(negedge clk); rsp_ready = 1'b0; #1;
`ifdef SUM_ARB_CARRY_CNT_EN
        total++;
        if (carry_cnt !== 16'd1) begin
            bad++; $display("FAIL carry_cnt: got %0d required 1", carry_cnt);
        end
`endif
    endtask

    task automatic test_round_robin();
        exp_t       e;
        int         grants;
        int         last;
        int         exp_idx;
        bit         drop;
        logic [3:0] onehot;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_ops(i, 32'h8000_0000 + 32'(i) * 32'h1111, 32'h7FFF_FFFF + 32'(i));
        end
        grants = 0; last = -1; exp_idx = 0; drop = 1'b0;
        @(negedge clk); req_valid = 4'hF; rsp_ready = 1'b1; #1;
        for (int cyc = 0; cyc < 40 && !(grants == 5 && sb.size() == 0); cyc++) begin
            if (rsp_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rr_rsp_extra: got id=%0d required no response", rsp_id);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c}) begin
                        bad++;
                        $display("FAIL rr_rsp: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b",
                                 rsp_id, rsp_sum, rsp_carry, e.id, e.s, e.c);
                    end
                end
            end
            if (req_ready !== 4'b0000) begin
                onehot = 4'b0001 << exp_idx;
                total++;
                if (req_ready !== onehot) begin
                    bad++; $display("FAIL rr_grant: got %b required %b", req_ready, onehot);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 3) begin
                        bad++; $display("FAIL rr_spacing: got %0d cycles required 3", cyc - last);
                    end
                end
                push_exp(exp_idx);
                last = cyc;
                grants++;
                exp_idx = (exp_idx + 1) % NR;
                if (grants == 5) drop = 1'b1;
            end
            @(negedge clk);
            if (drop) req_valid = '0;
            #1;
        end
        total++;
        if (grants != 5 || sb.size() != 0) begin
            bad++; $display("FAIL rr_count: got grants=%0d pending=%0d required 5 0", grants, sb.size());
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_pointer_skip();
        exp_t e;
        bit   ok;
        do_reset();
        set_ops(0, 32'd1, 32'd2);
        set_ops(3, 32'h10, 32'h20);
        rsp_ready = 1'b1;
        // One grant to requester 0 leaves rr_ptr at 1.
        @(negedge clk); req_valid = 4'b0001; #1;
        push_exp(0);
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL skip_first_timeout: rsp_valid=%b required 1", rsp_valid);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c}) begin
                bad++; $display("FAIL skip_first_rsp: got id=%0d sum=%h required id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.s);
            end
        end
        @(negedge clk); req_valid = 4'b1001; #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL skip_grant3: got %b required 1000", req_ready);
        end
        push_exp(3);
        @(negedge clk); req_valid = 4'b0001; #1;
        wait_rsp(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL skip3_timeout: rsp_valid=%b required 1", rsp_valid);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c}) begin
                bad++; $display("FAIL skip3_rsp: got id=%0d sum=%h required id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.s);
            end
        end
        @(negedge clk); req_valid = 4'b1001; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL skip_wrap_grant0: got %b required 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL skip0_timeout: rsp_valid=%b required 1", rsp_valid);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c}) begin
                bad++; $display("FAIL skip0_rsp: got id=%0d sum=%h required id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.s);
            end
        end
        @(negedge clk); rsp_ready = 1'b0; #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        do_reset();
        set_ops(1, 32'h1234_5678, 32'h1111_1111);
        @(negedge clk); req_valid = 4'b0010; #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_ready: got %b required 0010", req_ready);
        end
        push_exp(1);
        // Other requesters push during EXEC/RESP and must not be accepted.
        @(negedge clk); req_valid = 4'hF; #1;
        total++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL bp_exec: rdy=%b busy=%b required 0000 1", req_ready, busy);
        end
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c}) begin
            bad++; $display("FAIL bp_rsp: v=%b id=%0d sum=%h required v=1 id=%0d sum=%h", rsp_valid, rsp_id, rsp_sum, e.id, e.s);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready, busy} !== {1'b1, e.id, e.s, e.c, 4'b0000, 1'b1}) begin
                bad++;
                $display("FAIL bp_hold%0d: v=%b id=%0d sum=%h rdy=%b busy=%b required v=1 id=%0d sum=%h rdy=0000 busy=1",
                         i, rsp_valid, rsp_id, rsp_sum, req_ready, busy, e.id, e.s);
            end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL bp_handshake_ready: got %b required 0000", req_ready);
        end
        @(negedge clk); rsp_ready = 1'b0; #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            bad++; $display("FAIL bp_resume: v=%b rdy=%b required 0 0100", rsp_valid, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midop();
        exp_t e;
        bit   ok;
        bit   seen;
        set_ops(2, 32'd5, 32'd6);
        rsp_ready = 1'b1;
        @(negedge clk); req_valid = 4'b0100; #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL mid_ready: got %b required 0100", req_ready);
        end
        @(negedge clk); req_valid = '0; #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy: got %b required 1", busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: rdy=%b v=%b id=%0d sum=%h c=%b busy=%b required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy);
        end
        sb.delete();
        @(negedge clk); rst = 1'b0; #1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk); #1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL mid_no_rsp: got rsp_valid=1 required 0");
        end
        set_ops(0, 32'hA, 32'hB);
        req_valid = 4'hF; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_first_grant: got %b required 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL mid_timeout: rsp_valid=%b required 1", rsp_valid);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.s, e.c}) begin
                bad++; $display("FAIL mid_rsp: got id=%0d sum=%h required id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.s);
            end
        end
        @(negedge clk); rsp_ready = 1'b0; #1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pointer_skip();
        test_single();
        test_carry();
        test_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
